bim_ctrl: RTL and testbench

//  Controller for the 1024x2 bimodal predictor table RAM (registered read port, write port, write-to-read forwarding).

---
 rtl/bim_ctrl.sv | 128 ++++++++++++
 tb/tb_bim_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bim_ctrl.sv
// Bimodal predictor table controller: post-reset init sweep, then a single RAM read port shared
// between fetch lookups and queued 2-bit saturating read-modify-write updates.
module bim_ctrl #(
    parameter int         IDX_W      = 10,
    parameter int         UPD_DEPTH  = 4,
    parameter int         STARVE_MAX = 3,
    parameter logic [1:0] INIT_VAL   = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lkp_valid,
    output logic             lkp_ready,
    input  logic [IDX_W-1:0] lkp_idx,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [1:0]       pred_cnt,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic [IDX_W-1:0] ram_a,
    output logic [1:0]       ram_d,
    output logic             ram_we,
    output logic [IDX_W-1:0] ram_dpra,
    input  logic [1:0]       ram_q,
    output logic             init_done
);
    localparam int PTR_W = $clog2(UPD_DEPTH);
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state;
    logic [IDX_W-1:0] sweep;
    logic [IDX_W:0]   fifo_mem [UPD_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic [SC_W-1:0]  starve_ctr;
    logic             lkp_pend, upd_pend;
    logic [IDX_W-1:0] wb_idx;
    logic             wb_taken;
    logic [1:0]       sat_cnt;
    logic [IDX_W:0]   head;
    logic             run, empty, full, starve, lkp_acc, upd_rd, push;

    assign run     = (state == S_RUN);
    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(UPD_DEPTH));
    assign starve  = (starve_ctr == SC_W'(STARVE_MAX)) & !empty;
    assign head    = fifo_mem[rd_ptr];

    assign lkp_ready = run & !starve;
    assign upd_ready = run & !full;
    assign lkp_acc   = lkp_valid & lkp_ready;
    assign upd_rd    = run & !lkp_acc & !empty;
    assign push      = upd_valid & upd_ready;

    assign ram_dpra   = lkp_acc ? lkp_idx : head[IDX_W:1];
    assign pred_valid = lkp_pend;
    assign pred_cnt   = ram_q;
    assign pred_taken = ram_q[1];
    assign init_done  = run;

    always_comb begin
        sat_cnt = ram_q;
        if (wb_taken && ram_q != 2'b11)
            sat_cnt = ram_q + 2'b01;
        else if (!wb_taken && ram_q != 2'b00)
            sat_cnt = ram_q - 2'b01;
    end

    // Write enable is gated by rst so nothing reaches the RAM while reset is held.
    assign ram_we = !rst & ((state == S_INIT) | upd_pend);
    assign ram_a  = (state == S_INIT) ? sweep : wb_idx;
    assign ram_d  = (state == S_INIT) ? INIT_VAL : sat_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_INIT;
            sweep <= '0;
        end else if (state == S_INIT) begin
            sweep <= sweep + IDX_W'(1);
            if (sweep == '1)
                state <= S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {upd_idx, upd_taken};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_ctr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (upd_rd)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(upd_rd);
            // Counts lookup wins only while an update is waiting for the read port.
            if (upd_rd || empty)
                starve_ctr <= '0;
            else if (lkp_acc)
                starve_ctr <= starve_ctr + SC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lkp_pend <= 1'b0;
            upd_pend <= 1'b0;
            wb_idx   <= '0;
            wb_taken <= 1'b0;
        end else begin
            lkp_pend <= lkp_acc;
            upd_pend <= upd_rd;
            if (upd_rd) begin
                wb_idx   <= head[IDX_W:1];
                wb_taken <= head[0];
            end
        end
    end
endmodule

// File: tb/tb_bim_ctrl.sv
// Bench for bim_ctrl: RAM model with write-to-read forwarding, transaction-level scoreboard
// of the predictor table, directed scenario tasks and a randomized traffic run.
module tb_bim_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lkp_valid = 1'b0, lkp_ready;
    logic [9:0] lkp_idx = '0;
    logic       pred_valid, pred_taken;
    logic [1:0] pred_cnt;
    logic       upd_valid = 1'b0, upd_ready;
    logic [9:0] upd_idx = '0;
    logic       upd_taken = 1'b0;
    logic [9:0] ram_a, ram_dpra;
    logic [1:0] ram_d, ram_q;
    logic       ram_we, init_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bim_ctrl dut (
        .clk(clk), .rst(rst),
        .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_idx(lkp_idx),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_cnt(pred_cnt),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_dpra(ram_dpra), .ram_q(ram_q),
        .init_done(init_done)
    );

    // Table RAM: registered read, same-cycle write to the read address is forwarded.
    logic [1:0] mem [1024];
    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_d;
        ram_q <= (ram_we && ram_a == ram_dpra) ? ram_d : mem[ram_dpra];
    end

    // Reference: the table as an array, pending updates as a queue, applied in read-slot order.
    typedef struct { logic [9:0] idx; logic taken; } upd_t;
    logic [1:0] tbl [1024];
    upd_t       q[$];
    int         sc;
    bit         sb_on = 1'b0;
    bit         epv, ewe;
    logic [1:0] epc, ed;
    logic [9:0] ea;

    task automatic model_clear();
        foreach (tbl[i]) tbl[i] = 2'b01;
        q.delete();
        sc = 0; epv = 0; ewe = 0;
    endtask

    always @(negedge clk) begin
        bit         acc, exp_lr, exp_ur, nepv, newe;
        int         v;
        upd_t       u;
        if (sb_on) begin
            nepv = 0; newe = 0;
            n_tests++;
            if (init_done !== 1'b1) begin n_fail++; $display("FAIL sb_init_done: got %b need 1", init_done); end
            n_tests++;
            if (pred_valid !== epv) begin n_fail++; $display("FAIL sb_pred_valid: got %b need %b", pred_valid, epv); end
            if (epv) begin
                n_tests++;
                if (pred_cnt !== epc || pred_taken !== epc[1]) begin
                    n_fail++; $display("FAIL sb_pred: got cnt %b taken %b need cnt %b", pred_cnt, pred_taken, epc);
                end
            end
            n_tests++;
            if (ram_we !== ewe) begin n_fail++; $display("FAIL sb_ram_we: got %b need %b", ram_we, ewe); end
            if (ewe) begin
                n_tests++;
                if (ram_a !== ea || ram_d !== ed) begin
                    n_fail++; $display("FAIL sb_write: got a=%0d d=%b need a=%0d d=%b", ram_a, ram_d, ea, ed);
                end
            end
            exp_lr = !(sc == 3 && q.size() != 0);
            exp_ur = q.size() < 4;
            n_tests++;
            if (lkp_ready !== exp_lr || upd_ready !== exp_ur) begin
                n_fail++; $display("FAIL sb_ready: got lkp %b upd %b need lkp %b upd %b", lkp_ready, upd_ready, exp_lr, exp_ur);
            end
            acc = lkp_valid && exp_lr;
            if (acc) begin
                n_tests++;
                if (ram_dpra !== lkp_idx) begin n_fail++; $display("FAIL sb_dpra_lkp: got %0d need %0d", ram_dpra, lkp_idx); end
                epc = tbl[lkp_idx]; nepv = 1;
                sc = (q.size() != 0) ? sc + 1 : 0;
            end else if (q.size() != 0) begin
                u = q.pop_front();
                n_tests++;
                if (ram_dpra !== u.idx) begin n_fail++; $display("FAIL sb_dpra_upd: got %0d need %0d", ram_dpra, u.idx); end
                v = int'(tbl[u.idx]);
                v = u.taken ? ((v < 3) ? v + 1 : 3) : ((v > 0) ? v - 1 : 0);
                tbl[u.idx] = 2'(v);
                ea = u.idx; ed = 2'(v); newe = 1;
                sc = 0;
            end else begin
                sc = 0;
            end
            if (upd_valid && exp_ur) begin
                u.idx = upd_idx; u.taken = upd_taken;
                q.push_back(u);
            end
            epv = nepv; ewe = newe;
        end
    end

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({ram_we, lkp_ready, upd_ready, pred_valid, init_done} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b need 00000", {ram_we, lkp_ready, upd_ready, pred_valid, init_done});
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (ram_we !== 1'b1 || ram_a !== 10'(i) || ram_d !== 2'b01 ||
                lkp_ready !== 1'b0 || upd_ready !== 1'b0 || init_done !== 1'b0) begin
                if (bad < 4) $display("FAIL sweep_cycle: at %0d got we=%b a=%0d d=%b rdy=%b%b done=%b", i, ram_we, ram_a, ram_d, lkp_ready, upd_ready, init_done);
                bad++;
            end
            @(posedge clk);
        end
        n_tests++;
        if (bad != 0) n_fail++;
        #1;
        @(negedge clk);
        n_tests++;
        if (init_done !== 1'b1 || ram_we !== 1'b0 || lkp_ready !== 1'b1 || upd_ready !== 1'b1) begin
            n_fail++; $display("FAIL init_done_after_sweep: got done=%b we=%b rdy=%b%b need 1 0 11", init_done, ram_we, lkp_ready, upd_ready);
        end
        @(posedge clk); #1;
        model_clear();
        sb_on = 1'b1;
    endtask

    task automatic test_lookup_basic();
        lkp_valid = 1'b1; lkp_idx = 10'd5;
        @(negedge clk);
        n_tests++;
        if (lkp_ready !== 1'b1) begin n_fail++; $display("FAIL lookup_ready: got %b need 1", lkp_ready); end
        @(posedge clk); #1 lkp_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (pred_valid !== 1'b1 || pred_cnt !== 2'b01 || pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL lookup_init_val: got v=%b cnt=%b t=%b need 1 01 0", pred_valid, pred_cnt, pred_taken);
        end
        @(posedge clk); #1;
    endtask

    // Offer n back-to-back updates to one index, then collect the writes and look the index up.
    task automatic run_updates(input string name, input logic [9:0] idx, input logic tk, input int n,
                               input logic [1:0] w0, input logic [1:0] w1, input logic [1:0] w2,
                               input logic [1:0] final_cnt);
        logic [1:0] want [3];
        logic [1:0] seen [$];
        want[0] = w0; want[1] = w1; want[2] = w2;
        for (int i = 0; i < n + 7; i++) begin
            upd_valid = (i < n); upd_idx = idx; upd_taken = tk;
            @(negedge clk);
            if (i < n) begin
                n_tests++;
                if (upd_ready !== 1'b1) begin n_fail++; $display("FAIL %s_upd_ready: got %b need 1", name, upd_ready); end
            end
            if (ram_we === 1'b1 && ram_a === idx) seen.push_back(ram_d);
            @(posedge clk); #1;
        end
        upd_valid = 1'b0;
        n_tests++;
        if (seen.size() != n) begin
            n_fail++; $display("FAIL %s_write_count: got %0d need %0d", name, seen.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                n_tests++;
                if (seen[i] !== want[i]) begin n_fail++; $display("FAIL %s_write_%0d: got %b need %b", name, i, seen[i], want[i]); end
            end
        end
        lkp_valid = 1'b1; lkp_idx = idx;
        @(posedge clk); #1 lkp_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (pred_valid !== 1'b1 || pred_cnt !== final_cnt || pred_taken !== final_cnt[1]) begin
            n_fail++; $display("FAIL %s_lookup: got v=%b cnt=%b t=%b need 1 %b %b", name, pred_valid, pred_cnt, pred_taken, final_cnt, final_cnt[1]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_update_taken();
        run_updates("upd_taken", 10'd5, 1'b1, 3, 2'b10, 2'b11, 2'b11, 2'b11);
    endtask

    task automatic test_update_not_taken();
        run_updates("upd_nt", 10'd7, 1'b0, 2, 2'b00, 2'b00, 2'b00, 2'b00);
    endtask

    task automatic test_starve();
        logic [5:0] want_rdy = 6'b101111;
        lkp_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            lkp_idx = 10'($urandom_range(1023));
            upd_valid = (c == 0); upd_idx = 10'd9; upd_taken = 1'b1;
            @(negedge clk);
            n_tests++;
            if (lkp_ready !== want_rdy[c]) begin n_fail++; $display("FAIL starve_lkp_ready_c%0d: got %b need %b", c, lkp_ready, want_rdy[c]); end
            if (c == 4) begin
                n_tests++;
                if (ram_dpra !== 10'd9) begin n_fail++; $display("FAIL starve_update_read: got %0d need 9", ram_dpra); end
            end
            @(posedge clk); #1;
        end
        lkp_valid = 1'b0; upd_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic test_full();
        logic [5:0] want_rdy = 6'b101111;
        int k = 0;
        lkp_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            lkp_idx = 10'($urandom_range(1023));
            upd_valid = 1'b1; upd_idx = 10'(20 + k); upd_taken = k[0];
            @(negedge clk);
            n_tests++;
            if (upd_ready !== want_rdy[c]) begin n_fail++; $display("FAIL full_upd_ready_c%0d: got %b need %b", c, upd_ready, want_rdy[c]); end
            if (upd_ready === 1'b1) k++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (k != 5) begin n_fail++; $display("FAIL full_push_count: got %0d need 5", k); end
        lkp_valid = 1'b0; upd_valid = 1'b0;
        repeat (10) @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_sweep();
        int bad = 0;
        int waited = 0;
        sb_on = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({ram_we, lkp_ready, upd_ready, pred_valid, init_done} !== 5'b0) begin
            n_fail++; $display("FAIL rerst_outputs: got %b need 00000", {ram_we, lkp_ready, upd_ready, pred_valid, init_done});
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ram_we !== 1'b1 || ram_a !== 10'(i)) bad++;
            @(posedge clk);
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL rerst_partial_sweep: got %0d bad cycles need 0", bad); end
        @(negedge clk); #2 rst = 1'b1;
        #1;
        n_tests++;
        if (ram_we !== 1'b0 || init_done !== 1'b0) begin
            n_fail++; $display("FAIL rerst_async: got we=%b done=%b need 0 0", ram_we, init_done);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ram_we !== 1'b1 || ram_a !== 10'd0 || ram_d !== 2'b01) begin
            n_fail++; $display("FAIL rerst_restart: got we=%b a=%0d d=%b need 1 0 01", ram_we, ram_a, ram_d);
        end
        while (init_done !== 1'b1 && waited < 1100) begin
            @(posedge clk); #1;
            waited++;
        end
        n_tests++;
        if (init_done !== 1'b1 || waited < 1023) begin
            n_fail++; $display("FAIL rerst_sweep_len: got %0d cycles done=%b need 1024 1", waited, init_done);
        end
        @(posedge clk); #1;
        model_clear();
        sb_on = 1'b1;
    endtask

    task automatic test_random();
        int nacc = 0;
        for (int c = 0; c < 1500; c++) begin
            lkp_valid = ($urandom_range(3) != 0);
            lkp_idx   = 10'($urandom_range(15));
            upd_valid = ($urandom_range(1) != 0);
            upd_idx   = 10'($urandom_range(15));
            upd_taken = ($urandom_range(2) != 0);
            @(negedge clk);
            if (lkp_valid && lkp_ready) nacc++;
            @(posedge clk); #1;
        end
        lkp_valid = 1'b0; upd_valid = 1'b0;
        repeat (12) @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            lkp_valid = 1'b1; lkp_idx = 10'(i);
            @(posedge clk); #1;
        end
        lkp_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (nacc == 0 || lkp_ready !== 1'b1 || upd_ready !== 1'b1) begin
            n_fail++; $display("FAIL random_idle: got acc=%0d rdy=%b%b need >0 11", nacc, lkp_ready, upd_ready);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_lookup_basic();
        test_update_taken();
        test_update_not_taken();
        test_starve();
        test_full();
        test_reset_mid_sweep();
        test_random();
        sb_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
